// File: rtl/valve_jk_driver.sv
// Command-side driver for a bank of JK valve latches: handshake, per-bit J/K excitation,
// read-back verify with bounded retry, post-change dwell and sticky safe-close fault.
// Optional build macro: VALVE_STAGGER_EN (switch mismatching valves one at a time).
module valve_jk_driver #(
  parameter int N_VALVES     = 4,
  parameter int DWELL_CYCLES = 16,
  parameter int MAX_RETRY    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_i,
  input  logic [N_VALVES-1:0] target_i,
  input  logic [N_VALVES-1:0] q_fb_i,
  input  logic                clear_i,
  output logic [N_VALVES-1:0] j_o,
  output logic [N_VALVES-1:0] k_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                fault_o
);

  localparam int DW = (DWELL_CYCLES > 0) ? $clog2(DWELL_CYCLES + 1) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef logic [N_VALVES-1:0] vmask_t;
  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_VERIFY, S_DWELL, S_FAULT} state_t;

  state_t          state_q, state_d;
  vmask_t          target_q, target_d;
  vmask_t          j_q, j_d, k_q, k_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic            done_q, done_d;
  logic            bit_done;
  vmask_t          check_mask;

`ifdef VALVE_STAGGER_EN
  // One-hot mask of the valve currently being switched.
  vmask_t          sel_q, sel_d;

  function automatic vmask_t lowest_bit(input vmask_t diff);
    return diff & (~diff + vmask_t'(1));
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      target_q <= '0;
      j_q      <= '0;
      k_q      <= '0;
      retry_q  <= '0;
      dwell_q  <= '0;
      done_q   <= 1'b0;
`ifdef VALVE_STAGGER_EN
      sel_q    <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      target_q <= target_d;
      j_q      <= j_d;
      k_q      <= k_d;
      retry_q  <= retry_d;
      dwell_q  <= dwell_d;
      done_q   <= done_d;
`ifdef VALVE_STAGGER_EN
      sel_q    <= sel_d;
`endif
    end
  end

  always_comb begin
    // NOTE: defaults first for every signal written here, so no latch is inferred.
    state_d    = state_q;
    target_d   = target_q;
    retry_d    = retry_q;
    dwell_d    = dwell_q;
    j_d        = '0;
    k_d        = '0;
    done_d     = 1'b0;
    bit_done   = 1'b0;
`ifdef VALVE_STAGGER_EN
    sel_d      = sel_q;
    check_mask = sel_q;
`else
    check_mask = '1;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (req_i) begin
          target_d = target_i;
          retry_d  = '0;
          if (target_i == q_fb_i) begin
            done_d = 1'b1;
          end else begin
            state_d = S_APPLY;
`ifdef VALVE_STAGGER_EN
            sel_d   = lowest_bit(target_i ^ q_fb_i);
`endif
          end
        end
      end
      S_APPLY: state_d = S_VERIFY;
      S_VERIFY: begin
        if (((q_fb_i ^ target_q) & check_mask) == '0) begin
          if (DWELL_CYCLES == 0) begin
            bit_done = 1'b1;
          end else begin
            state_d = S_DWELL;
            dwell_d = DW'(DWELL_CYCLES - 1);
          end
        end else if (retry_q < RW'(MAX_RETRY)) begin
          retry_d = retry_q + RW'(1);
          state_d = S_APPLY;
        end else begin
          // Safe close: drive every K for the first fault cycle.
          state_d = S_FAULT;
          retry_d = '0;
          k_d     = '1;
        end
      end
      S_DWELL: begin
        if (dwell_q == '0) bit_done = 1'b1;
        else               dwell_d  = dwell_q - DW'(1);
      end
      S_FAULT: begin
        if (clear_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (bit_done) begin
      retry_d = '0;
      state_d = S_IDLE;
      done_d  = 1'b1;
`ifdef VALVE_STAGGER_EN
      if ((target_q ^ q_fb_i) != '0) begin
        state_d = S_APPLY;
        done_d  = 1'b0;
        sel_d   = lowest_bit(target_q ^ q_fb_i);
      end
`endif
    end

    // Excitation is registered, so it is computed in the cycle before APPLY
    // from the feedback seen then; the latches hold still while J=K=0.
    if (state_d == S_APPLY) begin
`ifdef VALVE_STAGGER_EN
      j_d = target_d & ~q_fb_i & sel_d;
      k_d = ~target_d & q_fb_i & sel_d;
`else
      j_d = target_d & ~q_fb_i;
      k_d = ~target_d & q_fb_i;
`endif
    end
  end

  assign j_o     = j_q;
  assign k_o     = k_q;
  assign done_o  = done_q;
  assign busy_o  = (state_q == S_APPLY) || (state_q == S_VERIFY) || (state_q == S_DWELL);
  assign fault_o = (state_q == S_FAULT);

endmodule

// File: tb/tb_valve_jk_driver.sv
// Directed bench for valve_jk_driver with an ideal JK latch bank and a stuck-at-0 fault injector.
module tb_valve_jk_driver;

  logic       clk;
  logic       rst_n;
  logic       req;
  logic       clear;
  logic [3:0] target;
  logic [3:0] j, k, q_fb, latch_q, stuck_lo;
  logic       busy, done, fault;
  int         n_checks = 0;
  int         n_errors = 0;

`ifdef VALVE_STAGGER_EN
  localparam logic [3:0] CUR = 4'b1011;
`else
  localparam logic [3:0] CUR = 4'b0011;
`endif

  valve_jk_driver #(.N_VALVES(4), .DWELL_CYCLES(4), .MAX_RETRY(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req),
    .target_i (target),
    .q_fb_i   (q_fb),
    .clear_i  (clear),
    .j_o      (j),
    .k_o      (k),
    .busy_o   (busy),
    .done_o   (done),
    .fault_o  (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal JK latches sharing clock and reset with the driver.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) latch_q <= 4'b0000;
    else        latch_q <= (j & ~latch_q) | (~k & latch_q);
  end
  assign q_fb = latch_q & ~stuck_lo;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packs {J,K,BUSY,DONE,FAULT} into one comparison.
  task automatic expect_out(input string tag, input logic [3:0] ej, input logic [3:0] ek,
                            input logic eb, input logic ed, input logic ef);
    check(tag, 32'({j, k, busy, done, fault}), 32'({ej, ek, eb, ed, ef}));
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Called in the APPLY cycle; returns in the cycle after the last dwell cycle.
  task automatic run_op(input string tag, input logic [3:0] ej, input logic [3:0] ek,
                        input logic [3:0] eq);
    expect_out({tag, "_apply"}, ej, ek, 1'b1, 1'b0, 1'b0);
    step();
    expect_out({tag, "_verify"}, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    check({tag, "_qfb"}, 32'(q_fb), 32'(eq));
    for (int d = 1; d <= 4; d++) begin
      step();
      expect_out($sformatf("%s_dwell%0d", tag, d), 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    end
    step();
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = 1'b0;
    clear    = 1'b0;
    target   = 4'b0000;
    stuck_lo = 4'b0000;
    repeat (2) step();
    expect_out("reset_hold", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    expect_out("reset_idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

`ifdef VALVE_STAGGER_EN
    target = 4'b1011; req = 1'b1; step(); req = 1'b0;
    run_op("stg_bit0", 4'b0001, 4'b0000, 4'b0001);
    run_op("stg_bit1", 4'b0010, 4'b0000, 4'b0011);
    run_op("stg_bit3", 4'b1000, 4'b0000, 4'b1011);
    expect_out("stg_done", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    step();
    expect_out("stg_after_done", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
`else
    target = 4'b0101; req = 1'b1; step(); req = 1'b0;
    run_op("open", 4'b0101, 4'b0000, 4'b0101);
    expect_out("open_done", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    // Request during the DONE cycle must be accepted.
    target = 4'b0011; req = 1'b1; step(); req = 1'b0;
    run_op("mixed", 4'b0010, 4'b0100, 4'b0011);
    expect_out("mixed_done", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    step();
    expect_out("mixed_after_done", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
`endif

    // Target already matches the latches.
    target = CUR; req = 1'b1; step(); req = 1'b0;
    expect_out("nochg_c1", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    step();
    expect_out("nochg_c2", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("nochg_qfb", 32'(q_fb), 32'(CUR));

    // Asynchronous reset in the middle of the dwell.
    target = CUR | 4'b0100; req = 1'b1; step(); req = 1'b0;
    expect_out("rst_apply", 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0);
    repeat (3) step();
    expect_out("rst_in_dwell", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 expect_out("rst_async", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("rst_latch_qfb", 32'(q_fb), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    expect_out("rst_released", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Valve 2 stuck closed: three attempts, then safe close and sticky fault.
    stuck_lo = 4'b0100;
    target = 4'b0100; req = 1'b1; step(); req = 1'b0;
    for (int a = 0; a < 3; a++) begin
      expect_out($sformatf("stuck_apply%0d", a), 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0);
      step();
      expect_out($sformatf("stuck_verify%0d", a), 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
      step();
    end
    expect_out("fault_close", 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1);
    step();
    expect_out("fault_hold", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    target = 4'b0000; req = 1'b1; step();
    expect_out("fault_req_ignored", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    target = 4'b0100; clear = 1'b1; step(); req = 1'b0; clear = 1'b0;
    expect_out("clear_wins", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("cleared_idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Normal operation resumes after the fault is cleared.
    stuck_lo = 4'b0000;
    target = 4'b0100; req = 1'b1; step(); req = 1'b0;
    run_op("recover", 4'b0100, 4'b0000, 4'b0100);
    expect_out("recover_done", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/valve_jk_driver.md
# valve_jk_driver

Command-side driver for a bank of `jk_flip_flop` valve latches in the irrigation controller. It accepts a target valve mask over a REQ/BUSY/DONE handshake and computes the per-bit J/K excitation. It pulses J/K for one cycle, reads the latch outputs back to verify them, retries on mismatch, and enforces a dwell time between valve changes. A persistent mismatch forces all valves closed and raises a sticky fault.

## Interface
- `N_VALVES`, 4: number of valve latches driven.
- `DWELL_CYCLES`, 16: settle cycles after a verified change (0 allowed).
- `MAX_RETRY`, 2: re-applications after the first failed verify. Total attempts = MAX_RETRY+1.

- `CLK`  in  1: clock. It is shared with the valve latches.
- `RESET`  in  1: asynchronous reset, active low.
- `REQ`  in  1: request. Sampled only in IDLE.
- `TARGET`  in  N_VALVES: desired valve state, latched on acceptance.
- `Q_FB`  in  N_VALVES: latch Q outputs, synchronous to CLK, no synchronizer.
- `CLEAR`  in  1: leaves FAULT. Ignored in all other states.
- `J`  out  N_VALVES: J inputs to the latches (registered).
- `K`  out  N_VALVES: K inputs to the latches (registered).
- `BUSY`  out  1: high from the cycle after acceptance until the operation ends.
- `DONE`  out  1: one-cycle pulse on successful completion.
- `FAULT`  out  1: sticky verify failure.

## Operation
- Reset values: J=0, K=0, BUSY=0, DONE=0, FAULT=0, state IDLE, retry counter 0.
- RESET asserted mid-operation clears all outputs immediately and returns to IDLE. The latches are reset by their own RESET.
- States: IDLE, APPLY, VERIFY, DWELL, FAULT.
- **IDLE:** REQ=1 latches TARGET.
  - If TARGET equals Q_FB: no state change, DONE pulses in the next cycle, BUSY stays 0.
  - Otherwise: go to APPLY.
  - REQ in any state other than IDLE is ignored.
- **APPLY:** one cycle. Excitation per bit i, computed from the current Q_FB[i] toward target[i]:
  - 0→1: J=1, K=0
  - 1→0: J=0, K=1
  - no change: J=0, K=0
  - J=K=1 is never driven.
- **VERIFY:** one cycle. J=K=0. Compares Q_FB against target.
  - Match: go to DWELL, or to IDLE with DONE if DWELL_CYCLES=0.
  - Mismatch with retry counter < MAX_RETRY: increment the counter and go back to APPLY, with no dwell. J/K are recomputed from the current Q_FB.
  - Mismatch with counter = MAX_RETRY: go to FAULT.
- **DWELL:** J=K=0 for exactly DWELL_CYCLES cycles, then IDLE with a DONE pulse. The retry counter is cleared.
- **FAULT:** FAULT=1 and BUSY=0.
  - First FAULT cycle: J=0, K=all ones for one cycle (safe close). After that J=K=0.
  - CLEAR=1 returns to IDLE in the next cycle with FAULT=0.
  - CLEAR and REQ asserted in the same cycle: CLEAR wins, and REQ is not accepted.
- Counter widths: $clog2(DWELL_CYCLES+1) and $clog2(MAX_RETRY+1), with a minimum of 1 bit each.

## Timing
- Acceptance happens at clock edge E0. Cycles are numbered after E0.
  - Cycle 1: APPLY. J/K are valid and are captured by the latches at the end of the cycle.
  - Cycle 2: VERIFY, using the updated Q_FB.
  - Cycles 3 to DWELL_CYCLES+2: DWELL.
  - Cycle DWELL_CYCLES+3: IDLE, DONE=1, BUSY=0.
- BUSY=1 in cycles 1 to DWELL_CYCLES+2.
- Each retry adds 2 cycles.
- REQ asserted during the DONE cycle is accepted (the state is IDLE).

## Configuration
- `VALVE_STAGGER_EN`
  - **Defined:** mismatching bits are switched one at a time, lowest index first.
    - Each bit gets its own APPLY → VERIFY → DWELL sequence. J/K have only that bit set.
    - The retry counter is cleared per bit.
    - DONE pulses once, after the last bit's dwell.
    - A fault on any bit aborts the remaining bits.
  - **Undefined:** all mismatching bits are applied in the same APPLY cycle.

## Test plan
- **Reset:** assert RESET mid-DWELL → J, K, BUSY, DONE, FAULT all 0 asynchronously. The next REQ is accepted normally.
- **Open two valves:** N=4, D=4, Q_FB from ideal latches, 0000→0101.
  - Cycle 1: J=0101, K=0000.
  - BUSY high in cycles 1–6, DONE at cycle 7.
- **Mixed change:** 0101→0011 → APPLY shows J=0010, K=0100. Q_FB=0011 at VERIFY.
- **No change:** TARGET equals Q_FB=0011 → DONE at cycle 1, BUSY stays 0, J=K=0 throughout.
- **Stuck valve:** Q_FB[2] stuck at 0, target 0100, MAX_RETRY=2.
  - Three APPLY cycles with J=0100, each two cycles apart.
  - Then FAULT=1, with K=1111 for one cycle.
  - REQ is ignored while in FAULT. CLEAR returns to IDLE.
- **Staggered opening:** VALVE_STAGGER_EN defined, 0000→1011.
  - J pulses 0001, 0010, 1000 in order, each separated by VERIFY plus D dwell cycles.
  - A single DONE after the last dwell.
